// File: rtl/down_count_monitor.sv
// down_count_monitor: checks that a sampled count bus steps down by one per
// enabled cycle (0 wraps to all-ones), acquires/holds lock on the sequence,
// flags terminal-count and wrap events, and keeps a saturating step-error count.
module down_count_monitor #(
  parameter int WIDTH      = 4,
  parameter int ERR_W      = 8,
  parameter int LOCK_CNT   = 3,
  parameter int UNLOCK_ERR = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             clr_err,
  output logic             locked,
  output logic [1:0]       state,
  output logic             tc_pulse,
  output logic             wrap_pulse,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0]       S_IDLE   = 2'b00;
  localparam logic [1:0]       S_ACQ    = 2'b01;
  localparam logic [1:0]       S_LOCKED = 2'b10;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       good_q, good_d;
  logic [2:0]       bad_q, bad_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             tc_q, tc_d;
  logic             wrap_q, wrap_d;
  logic             serr_q, serr_d;
  logic             locked_q, locked_d;

  logic [WIDTH-1:0] expected;
  logic             match;
  logic [3:0]       good_inc, bad_inc;
  logic             lock_hit, unlock_hit;
  logic             samp_locked;

  // Next expected sample and run-length increments
  assign expected   = prev_q - WIDTH'(1);
  assign match      = (cnt_in == expected);
  assign good_inc   = {1'b0, good_q} + 4'd1;
  assign bad_inc    = {1'b0, bad_q} + 4'd1;
  assign lock_hit   = (good_inc == 4'(LOCK_CNT));
  assign unlock_hit = (bad_inc == 4'(UNLOCK_ERR));

  // State register plus sequence bookkeeping; asynchronous clear of everything
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      prev_q   <= '0;
      good_q   <= '0;
      bad_q    <= '0;
      err_q    <= '0;
      tc_q     <= 1'b0;
      wrap_q   <= 1'b0;
      serr_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      err_q    <= err_d;
      tc_q     <= tc_d;
      wrap_q   <= wrap_d;
      serr_q   <= serr_d;
      locked_q <= locked_d;
    end
  end

  // Next-state logic: acquisition / lock / unlock and the good/bad run counters
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    prev_d  = en ? cnt_in : prev_q;
    case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d = S_ACQ;
          good_d  = '0;
        end
      end
      S_ACQ: begin
        if (en) begin
          if (match) begin
            if (lock_hit) begin
              state_d = S_LOCKED;
              good_d  = '0;
              bad_d   = '0;
            end else begin
              good_d = good_inc[2:0];
            end
          end else begin
            good_d = '0;
          end
        end
      end
      S_LOCKED: begin
        if (en) begin
          if (match) begin
            bad_d = '0;
          end else if (unlock_hit) begin
            state_d = S_ACQ;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            bad_d = bad_inc[2:0];
          end
        end
      end
      default: begin
        // Unused encoding recovers to IDLE
        state_d = S_IDLE;
        good_d  = '0;
        bad_d   = '0;
      end
    endcase
  end

  // Output logic: pulses qualified by the pre-sample state, saturating error count
  always_comb begin
    samp_locked = en && (state_q == S_LOCKED);
    tc_d        = samp_locked && match && (cnt_in == '0);
    wrap_d      = samp_locked && match && (cnt_in == ALL_ONES);
    serr_d      = samp_locked && !match;
    locked_d    = (state_d == S_LOCKED);
    err_d       = err_q;
    if (clr_err) begin
      err_d = '0;
    end else if (serr_d && (err_q != ERR_MAX)) begin
      err_d = err_q + ERR_W'(1);
    end
  end

  assign state      = state_q;
  assign locked     = locked_q;
  assign tc_pulse   = tc_q;
  assign wrap_pulse = wrap_q;
  assign step_err   = serr_q;
  assign err_count  = err_q;

endmodule
